// File: rtl/ghostbus_arb_pkg.sv
// Shared types and constants for the ghostbus host-port arbiter.
package ghostbus_arb_pkg;

  localparam int unsigned GIDX_W = 3;
  localparam int unsigned CNT_W  = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } gb_state_e;

  // One-hot decode of a requester index (up to 8 requesters).
  function automatic logic [7:0] gidx_onehot(input logic [GIDX_W-1:0] idx);
    return 8'(1) << idx;
  endfunction

endpackage

// File: rtl/ghostbus_arb_rr_pick.sv
// Combinational round-robin picker: first set request after 'last', wrapping.
module ghostbus_arb_rr_pick
  import ghostbus_arb_pkg::*;
#(
  parameter int unsigned NREQ = 2
) (
  input  logic [NREQ-1:0]   req,
  input  logic [GIDX_W-1:0] last,
  output logic              any_req,
  output logic [NREQ-1:0]   gnt,
  output logic [GIDX_W-1:0] gnt_idx
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  int unsigned cand;

  always_comb begin
    any_req = 1'b0;
    gnt     = '0;
    gnt_idx = '0;
    cand    = 0;
    for (int unsigned k = 1; k <= NREQ; k++) begin
      cand = 32'(last) + k;
      if (cand >= NREQ) cand = cand - NREQ;
      if (!any_req && req[IW'(cand)]) begin
        any_req           = 1'b1;
        gnt[IW'(cand)]    = 1'b1;
        gnt_idx           = GIDX_W'(cand);
      end
    end
  end

endmodule

// File: rtl/ghostbus_arb.sv
// Round-robin arbiter sharing one ghostbus host port between NREQ requesters;
// one single-beat read or write per grant, read data returned after RD_LAT.
module ghostbus_arb
  import ghostbus_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 2,
  parameter int unsigned GB_AW  = 12,
  parameter int unsigned GB_DW  = 32,
  parameter int unsigned RD_LAT = 1
) (
  input  logic                  gb_clk,
  input  logic                  gb_rst_n,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ-1:0]       req_we,
  input  logic [NREQ*GB_AW-1:0] req_addr,
  input  logic [NREQ*GB_DW-1:0] req_wdata,
  output logic [NREQ-1:0]       req_ready,
  output logic [NREQ-1:0]       rsp_valid,
  output logic [GB_DW-1:0]      rsp_rdata,
  output logic                  busy,
  output logic [2:0]            grant_idx,
  output logic [GB_AW-1:0]      gb_addr,
  output logic [GB_DW-1:0]      gb_dout,
  output logic                  gb_we,
  input  logic [GB_DW-1:0]      gb_din
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;

  gb_state_e          state_q, state_d;
  logic [GIDX_W-1:0]  last_q, last_d, grant_idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [GB_AW-1:0]   gb_addr_d;
  logic [GB_DW-1:0]   gb_dout_d, rsp_rdata_d;
  logic               gb_we_d, busy_d;
  logic [NREQ-1:0]    rsp_valid_d;

  logic               pick_any;
  logic [NREQ-1:0]    pick_gnt;
  logic [GIDX_W-1:0]  pick_idx;

  logic [GB_AW-1:0]   addr_a  [NREQ];
  logic [GB_DW-1:0]   wdata_a [NREQ];

  for (genvar i = 0; i < NREQ; i++) begin : g_unpack
    assign addr_a[i]  = req_addr[i*GB_AW +: GB_AW];
    assign wdata_a[i] = req_wdata[i*GB_DW +: GB_DW];
  end

  ghostbus_arb_rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req_valid),
    .last    (last_q),
    .any_req (pick_any),
    .gnt     (pick_gnt),
    .gnt_idx (pick_idx)
  );

  // State and registered outputs; reset abandons any transaction in flight.
  always_ff @(posedge gb_clk or negedge gb_rst_n) begin
    if (!gb_rst_n) begin
      state_q   <= ST_IDLE;
      last_q    <= GIDX_W'(NREQ - 1);
      grant_idx <= '0;
      cnt_q     <= '0;
      gb_addr   <= '0;
      gb_dout   <= '0;
      gb_we     <= 1'b0;
      rsp_valid <= '0;
      rsp_rdata <= '0;
      busy      <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_q    <= last_d;
      grant_idx <= grant_idx_d;
      cnt_q     <= cnt_d;
      gb_addr   <= gb_addr_d;
      gb_dout   <= gb_dout_d;
      gb_we     <= gb_we_d;
      rsp_valid <= rsp_valid_d;
      rsp_rdata <= rsp_rdata_d;
      busy      <= busy_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    last_d      = last_q;
    grant_idx_d = grant_idx;
    cnt_d       = cnt_q;
    gb_addr_d   = gb_addr;
    gb_dout_d   = gb_dout;
    gb_we_d     = 1'b0;
    rsp_valid_d = '0;
    rsp_rdata_d = rsp_rdata;
    req_ready   = '0;

    case (state_q)
      ST_IDLE: begin
        if (pick_any && gb_rst_n) begin
          req_ready   = pick_gnt;
          state_d     = ST_ISSUE;
          last_d      = pick_idx;
          grant_idx_d = pick_idx;
          gb_addr_d   = addr_a[IW'(pick_idx)];
          gb_dout_d   = wdata_a[IW'(pick_idx)];
          gb_we_d     = req_we[IW'(pick_idx)];
        end
      end
      ST_ISSUE: begin
        // gb_we is high exactly in ISSUE for writes, so it doubles as the op type.
        if (gb_we) begin
          state_d     = ST_RESP;
          rsp_valid_d = NREQ'(gidx_onehot(grant_idx));
        end else begin
          state_d = ST_WAIT;
          cnt_d   = CNT_W'(RD_LAT);
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          rsp_rdata_d = gb_din;
          rsp_valid_d = NREQ'(gidx_onehot(grant_idx));
          state_d     = ST_RESP;
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

endmodule

// File: tb/tb_ghostbus_arb.sv
// Bench for ghostbus_arb: two instances (RD_LAT=1 and RD_LAT=3), a transaction
// timeline model per instance checked every cycle, plus directed literal checks.
module tb_ghostbus_arb;

  logic gb_clk = 1'b0;
  logic gb_rst_n = 1'b0;
  always #5 gb_clk = ~gb_clk;

  logic [1:0]  req_valid [2];
  logic [1:0]  req_we    [2];
  logic [23:0] req_addr  [2];
  logic [63:0] req_wdata [2];
  logic [1:0]  req_ready [2];
  logic [1:0]  rsp_valid [2];
  logic [31:0] rsp_rdata [2];
  logic        busy      [2];
  logic [2:0]  grant_idx [2];
  logic [11:0] gb_addr   [2];
  logic [31:0] gb_dout   [2];
  logic        gb_we     [2];
  logic [31:0] gb_din    [2];

  int checks = 0;
  int failures = 0;

  function automatic logic [31:0] bus_mem(input logic [11:0] a);
    case (a)
      12'h000: return 32'h0000_0042;
      12'h200: return 32'hDEAD_BEEF;
      default: return {8'hA5, 12'h000, a};
    endcase
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  for (genvar gi = 0; gi < 2; gi++) begin : g_inst
    localparam int unsigned L = (gi == 0) ? 1 : 3;

    logic [31:0] pipe [L];

    ghostbus_arb #(.NREQ(2), .GB_AW(12), .GB_DW(32), .RD_LAT(L)) u_dut (
      .gb_clk    (gb_clk),
      .gb_rst_n  (gb_rst_n),
      .req_valid (req_valid[gi]),
      .req_we    (req_we[gi]),
      .req_addr  (req_addr[gi]),
      .req_wdata (req_wdata[gi]),
      .req_ready (req_ready[gi]),
      .rsp_valid (rsp_valid[gi]),
      .rsp_rdata (rsp_rdata[gi]),
      .busy      (busy[gi]),
      .grant_idx (grant_idx[gi]),
      .gb_addr   (gb_addr[gi]),
      .gb_dout   (gb_dout[gi]),
      .gb_we     (gb_we[gi]),
      .gb_din    (gb_din[gi])
    );

    // Decode tree stand-in: read data appears L cycles after the address.
    always @(posedge gb_clk) begin
      pipe[0] <= bus_mem(gb_addr[gi]);
      for (int j = 1; j < L; j++) pipe[j] <= pipe[j-1];
    end
    assign gb_din[gi] = pipe[L-1];

    // Timeline model: a grant at cycle c issues at c+1 and completes at
    // c+2 (write) or c+2+L (read); the port is free again the cycle after.
    longint      cyc = 0;
    longint      m_issue = -10;
    longint      m_resp = -10;
    longint      m_free = 0;
    int          m_last = 1;
    int          m_own = 0;
    logic        m_we = 1'b0;
    logic [11:0] m_addr = '0;
    logic [31:0] m_dout = '0;
    logic [31:0] m_rdata = '0;
    logic [2:0]  m_gidx = '0;

    always @(negedge gb_clk) begin : model
      int g;
      logic [1:0] e_ready;
      logic [1:0] e_rsp;
      cyc++;
      g = -1;
      e_ready = '0;
      e_rsp = '0;
      if (!gb_rst_n) begin
        m_last = 1; m_gidx = '0; m_addr = '0; m_dout = '0; m_rdata = '0;
        m_issue = -10; m_resp = -10; m_free = cyc + 1;
      end else begin
        if (cyc >= m_free && req_valid[gi] != 2'b00) begin
          for (int k = 1; k <= 2; k++) begin
            if (g < 0 && req_valid[gi][(m_last + k) % 2]) g = (m_last + k) % 2;
          end
        end
        if (g >= 0) e_ready[g] = 1'b1;
        if (cyc == m_resp && !m_we) m_rdata = bus_mem(m_addr);
      end
      if (cyc == m_resp) e_rsp[m_own] = 1'b1;

      check($sformatf("i%0d_req_ready", gi), 64'(req_ready[gi]), 64'(e_ready));
      check($sformatf("i%0d_busy", gi), 64'(busy[gi]), 64'(cyc >= m_issue && cyc <= m_resp));
      check($sformatf("i%0d_gb_we", gi), 64'(gb_we[gi]), 64'(cyc == m_issue && m_we));
      check($sformatf("i%0d_rsp_valid", gi), 64'(rsp_valid[gi]), 64'(e_rsp));
      check($sformatf("i%0d_rsp_rdata", gi), 64'(rsp_rdata[gi]), 64'(m_rdata));
      check($sformatf("i%0d_gb_addr", gi), 64'(gb_addr[gi]), 64'(m_addr));
      check($sformatf("i%0d_gb_dout", gi), 64'(gb_dout[gi]), 64'(m_dout));
      check($sformatf("i%0d_grant_idx", gi), 64'(grant_idx[gi]), 64'(m_gidx));

      if (g >= 0) begin
        m_last  = g;
        m_own   = g;
        m_gidx  = 3'(g);
        m_we    = req_we[gi][g];
        m_addr  = req_addr[gi][g*12 +: 12];
        m_dout  = req_wdata[gi][g*32 +: 32];
        m_issue = cyc + 1;
        m_resp  = cyc + 2 + (m_we ? 0 : L);
        m_free  = m_resp + 1;
      end
    end
  end

  task automatic tick();
    @(posedge gb_clk);
    #1;
  endtask

  task automatic set_req(input int k, input int r, input logic we,
                         input logic [11:0] addr, input logic [31:0] wdata);
    req_we[k][r] = we;
    req_addr[k][r*12 +: 12] = addr;
    req_wdata[k][r*32 +: 32] = wdata;
    req_valid[k][r] = 1'b1;
  endtask

  // Returns at the falling edge of the cycle in which req_ready[k][r] is seen.
  task automatic wait_ready(input int k, input int r);
    int n;
    n = 0;
    forever begin
      @(negedge gb_clk);
      if (req_ready[k][r]) break;
      n++;
      if (n >= 50) begin
        failures++;
        $display("FAIL wait_ready_timeout inst=%0d req=%0d got=none exp=req_ready", k, r);
        break;
      end
    end
  endtask

  task automatic wait_idle(input int k);
    int n;
    n = 0;
    forever begin
      @(negedge gb_clk);
      if (!busy[k]) break;
      n++;
      if (n >= 50) begin
        failures++;
        $display("FAIL wait_idle_timeout inst=%0d got=busy exp=idle", k);
        break;
      end
    end
  endtask

  initial begin
    int gs [4];
    int gt [4];
    int exp_gs [4];
    int ng;
    int t;
    int we_cnt;
    int r1_cnt;

    exp_gs = '{0, 1, 0, 1};
    for (int k = 0; k < 2; k++) begin
      req_valid[k] = '0; req_we[k] = '0; req_addr[k] = '0; req_wdata[k] = '0;
    end

    // Reset values
    repeat (2) @(negedge gb_clk);
    check("rst_busy", 64'(busy[0]), 64'd0);
    check("rst_grant_idx", 64'(grant_idx[0]), 64'd0);
    check("rst_rsp_valid", 64'(rsp_valid[1]), 64'd0);
    tick();
    gb_rst_n = 1'b1;

    // Contention on RD_LAT=1: both requesters hold reads
    set_req(0, 0, 1'b0, 12'h010, 32'h0);
    set_req(0, 1, 1'b0, 12'h020, 32'h0);
    ng = 0;
    t = 0;
    while (ng < 4 && t < 60) begin
      @(negedge gb_clk);
      if (req_ready[0] != 2'b00) begin
        gs[ng] = req_ready[0][1] ? 1 : 0;
        gt[ng] = t;
        ng++;
      end
      t++;
    end
    tick();
    req_valid[0] = 2'b00;
    check("cont_grant_count", 64'(ng), 64'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < ng) check($sformatf("cont_grant_%0d", i), 64'(gs[i]), 64'(exp_gs[i]));
      if (i > 0 && i < ng) check($sformatf("cont_spacing_%0d", i), 64'(gt[i] - gt[i-1]), 64'd4);
    end
    wait_idle(0);

    // Single write, requester 0
    tick();
    set_req(0, 0, 1'b1, 12'h040, 32'h5);
    wait_ready(0, 0);
    check("wr_ready", 64'(req_ready[0]), 64'h1);
    tick();
    req_valid[0][0] = 1'b0;
    @(negedge gb_clk);
    check("wr_gb_we", 64'(gb_we[0]), 64'd1);
    check("wr_gb_addr", 64'(gb_addr[0]), 64'h040);
    check("wr_gb_dout", 64'(gb_dout[0]), 64'h5);
    @(negedge gb_clk);
    check("wr_gb_we_drop", 64'(gb_we[0]), 64'd0);
    check("wr_rsp_valid", 64'(rsp_valid[0]), 64'h1);
    @(negedge gb_clk);
    check("wr_idle", 64'(busy[0]), 64'd0);

    // Single read, RD_LAT=1
    tick();
    set_req(0, 0, 1'b0, 12'h000, 32'h0);
    wait_ready(0, 0);
    tick();
    req_valid[0][0] = 1'b0;
    @(negedge gb_clk);
    check("rd1_issue_we", 64'(gb_we[0]), 64'd0);
    @(negedge gb_clk);
    check("rd1_wait_rsp", 64'(rsp_valid[0]), 64'd0);
    @(negedge gb_clk);
    check("rd1_rsp_valid", 64'(rsp_valid[0]), 64'h1);
    check("rd1_rsp_rdata", 64'(rsp_rdata[0]), 64'h42);

    // Request withdrawn while busy is never issued
    tick();
    set_req(0, 0, 1'b1, 12'h100, 32'h1234);
    wait_ready(0, 0);
    tick();
    req_valid[0][0] = 1'b0;
    set_req(0, 1, 1'b0, 12'h0AA, 32'h0);
    tick();
    req_valid[0][1] = 1'b0;
    we_cnt = 0;
    r1_cnt = 0;
    repeat (8) begin
      @(negedge gb_clk);
      if (gb_we[0]) we_cnt++;
      if (rsp_valid[0][1]) r1_cnt++;
    end
    check("wd_no_gb_we", 64'(we_cnt), 64'd0);
    check("wd_no_rsp1", 64'(r1_cnt), 64'd0);

    // Write from requester 1 at the top address
    tick();
    set_req(0, 1, 1'b1, 12'hFFF, 32'hCAFE_0001);
    wait_ready(0, 1);
    check("wr1_ready", 64'(req_ready[0]), 64'h2);
    tick();
    req_valid[0][1] = 1'b0;
    wait_idle(0);

    // RD_LAT=3 read, then a write must leave rsp_rdata alone
    tick();
    set_req(1, 0, 1'b0, 12'h200, 32'h0);
    wait_ready(1, 0);
    check("rd3_ready", 64'(req_ready[1]), 64'h1);
    tick();
    req_valid[1][0] = 1'b0;
    @(negedge gb_clk);
    check("rd3_issue_busy", 64'(busy[1]), 64'd1);
    for (int i = 0; i < 3; i++) begin
      @(negedge gb_clk);
      check($sformatf("rd3_wait_%0d", i), 64'({busy[1], rsp_valid[1]}), 64'b100);
    end
    @(negedge gb_clk);
    check("rd3_rsp_valid", 64'(rsp_valid[1]), 64'h1);
    check("rd3_rsp_rdata", 64'(rsp_rdata[1]), 64'hDEAD_BEEF);
    tick();
    set_req(1, 1, 1'b1, 12'h300, 32'h77);
    wait_ready(1, 1);
    tick();
    req_valid[1][1] = 1'b0;
    @(negedge gb_clk);
    check("wr3_gb_we", 64'(gb_we[1]), 64'd1);
    @(negedge gb_clk);
    check("wr3_rsp_valid", 64'(rsp_valid[1]), 64'h2);
    check("wr3_rdata_kept", 64'(rsp_rdata[1]), 64'hDEAD_BEEF);

    // Reset during WAIT abandons the read; requester 0 wins first afterwards
    tick();
    set_req(1, 1, 1'b0, 12'h123, 32'h0);
    wait_ready(1, 1);
    tick();
    req_valid[1][1] = 1'b0;
    tick();
    #2;
    gb_rst_n = 1'b0;
    #1;
    check("arst_busy", 64'(busy[1]), 64'd0);
    check("arst_gb_addr", 64'(gb_addr[1]), 64'd0);
    check("arst_rsp_rdata", 64'(rsp_rdata[1]), 64'd0);
    check("arst_grant_idx", 64'(grant_idx[1]), 64'd0);
    set_req(1, 0, 1'b1, 12'h055, 32'h55);
    set_req(1, 1, 1'b0, 12'h066, 32'h0);
    @(negedge gb_clk);
    check("arst_no_ready", 64'(req_ready[1]), 64'd0);
    tick();
    gb_rst_n = 1'b1;
    @(negedge gb_clk);
    check("post_rst_first_grant", 64'(req_ready[1]), 64'h1);
    tick();
    req_valid[1][0] = 1'b0;
    wait_ready(1, 1);
    tick();
    req_valid[1][1] = 1'b0;
    wait_idle(1);

    tick();
    repeat (3) @(negedge gb_clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    failures++;
    $display("FAIL watchdog got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ghostbus_arb.md
Name: ghostbus_arb

Overview:
- Round-robin arbiter that shares one ghostbus host port (gb_addr/gb_dout/gb_we/gb_din) between NREQ requesters, e.g. a UART bridge and a local sequencer.
- Sits above the top-level ghostbus decode tree.
- Issues one single-beat read or write per grant, waits out the tree's registered read latency, and returns read data to the owning requester.

Parameters:
- NREQ, 2, number of requesters (2..8).
- GB_AW, 12, ghostbus address width.
- GB_DW, 32, ghostbus data width.
- RD_LAT, 1, gb_din valid this many cycles after gb_addr is presented (1..7).

Ports:
- gb_clk  input  1  bus clock; all logic on posedge.
- gb_rst_n  input  1  asynchronous active-low reset.
- req_valid  input  NREQ  per-requester transaction request.
- req_we  input  NREQ  1=write, 0=read.
- req_addr  input  NREQ*GB_AW  packed addresses; requester i at [i*GB_AW +: GB_AW].
- req_wdata  input  NREQ*GB_DW  packed write data.
- req_ready  output  NREQ  one-hot accept pulse.
- rsp_valid  output  NREQ  one-hot completion pulse.
- rsp_rdata  output  GB_DW  read data, shared by all requesters.
- busy  output  1  transaction in flight.
- grant_idx  output  3  index of the current/last granted requester.
- gb_addr  output  GB_AW  ghostbus address.
- gb_dout  output  GB_DW  ghostbus write data.
- gb_we  output  1  ghostbus write strobe.
- gb_din  input  GB_DW  ghostbus read data.

Behaviour:
- Reset (async assert, sync release): state=IDLE.
  - gb_addr, gb_dout, gb_we, req_ready, rsp_valid, rsp_rdata, busy = 0.
  - grant_idx = 0. Round-robin pointer last = NREQ-1, so requester 0 wins first.
  - Reset mid-transaction abandons it: no rsp_valid is issued and gb_we drops immediately.
- Requester protocol:
  - Hold req_valid, req_we, req_addr and req_wdata stable until req_ready is seen.
  - req_ready is a single-cycle pulse, combinational from IDLE state and req_valid.
  - Requests dropped before req_ready are never issued.
  - A requester is not re-granted before its rsp_valid has been issued.
- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If any req_valid, pick the first set bit scanning last+1, last+2, ... modulo NREQ.
  - Assert req_ready[g] that cycle; register g into last and grant_idx; latch addr, wdata and we; go to ISSUE.
  - If no request, stay in IDLE with busy=0.
- ISSUE (one cycle):
  - gb_addr and gb_dout driven from the latches (registered outputs, updated on the IDLE->ISSUE edge).
  - gb_we=1 for writes only.
  - Write -> RESP. Read -> WAIT with counter = RD_LAT.
- gb_we is high in exactly one cycle per write and never during a read.
- gb_addr and gb_dout keep their last value outside ISSUE; gb_din is sampled at that address.
- WAIT:
  - Counter decrements each cycle.
  - On the cycle the counter reaches 1, sample gb_din into rsp_rdata and go to RESP.
  - Read issued at ISSUE cycle T with RD_LAT=1: gb_din sampled at end of T+1, rsp_valid at T+2.
- RESP (one cycle):
  - rsp_valid[g]=1, then go to IDLE.
  - rsp_rdata holds until the next read completes; writes leave it unchanged.
- Throughput: write = 3 cycles (IDLE, ISSUE, RESP); read = 3+RD_LAT cycles.
- Requests arriving during a transaction wait and are arbitrated in the next IDLE cycle.
- busy=1 in ISSUE, WAIT and RESP.
- Simultaneous requests: exactly one is granted per IDLE cycle; round-robin guarantees each active requester is served within NREQ grants.
- Out-of-range requester widths are not checked; NREQ>8 is illegal (grant_idx is 3 bits).

Decomposition:
- Shared include ghostbus_arb_defs.vh holds the FSM state localparams (2-bit encoding) and the RD_LAT counter width (3).
- One natural sub-module, rr_pick: combinational round-robin picker, NREQ-wide request vector plus last pointer in, one-hot grant plus index out.
  - Reused later by a multi-master CSR bridge.

Test Plan:
- Single write: req_valid[0], addr=12'h040, wdata=32'h5 -> req_ready[0] next-edge pulse; gb_we=1 for exactly one cycle with gb_addr=12'h040, gb_dout=5; rsp_valid[0] the following cycle.
- Single read, RD_LAT=1: bus model registers din=32'h42 for addr 0 -> rsp_valid[0] at ISSUE+2 with rsp_rdata=32'h42; gb_we stays 0 throughout.
- Contention: both requesters hold reads continuously -> grants alternate 0,1,0,1; grant_idx follows the grants; no requester starves; each rsp_valid lands on the correct bit.
- RD_LAT=3, read of addr 12'h200 returning 32'hDEAD_BEEF -> WAIT lasts 3 cycles; rsp_rdata=32'hDEADBEEF; a subsequent write leaves rsp_rdata unchanged.
- Reset asserted during WAIT -> all outputs 0 asynchronously; no rsp_valid; first grant after release goes to requester 0 even if requester 1 is also requesting.
- Request withdrawn: req_valid[1] pulsed while busy and dropped before IDLE -> never issued; no gb_we and no rsp_valid[1].
